// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store master and the data-memory responder.
// Signal names follow the memory-port naming used by the surrounding core.
interface dmem_responder_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        RdValid;
  logic        Ready;
  logic        AdrErr;
  logic        ProtoErr;
  logic        WatchHit;
  logic [15:0] WrCount;

  modport master (
    output MemWrite, MemRead, DataAdr, WriteData,
    input  ReadData, RdValid, Ready, AdrErr, ProtoErr, WatchHit, WrCount
  );

  modport slave (
    input  MemWrite, MemRead, DataAdr, WriteData,
    output ReadData, RdValid, Ready, AdrErr, ProtoErr, WatchHit, WrCount
  );
endinterface

// File: rtl/dmem_responder.sv
// 64 x 32-bit data memory with single-cycle writes, two-cycle reads, sticky error
// flags, a completion watch on one address/data pair and a saturating write counter.
module dmem_responder #(
  parameter logic [31:0] WATCH_ADR  = 32'd64,
  parameter logic [31:0] WATCH_DATA = 32'd64
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   mem_d [DEPTH];
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic            rd_ok_q, rd_ok_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rd_valid_q, rd_valid_d;
  logic            ready_q, ready_d;
  logic            adr_err_q, adr_err_d;
  logic            proto_err_q, proto_err_d;
  logic            watch_q, watch_d;
  logic [CW-1:0]   wr_count_q, wr_count_d;

  logic            adr_ok;
  logic [AW-1:0]   adr_idx;

  // Word aligned and inside the 256-byte window.
  assign adr_ok  = (bus.DataAdr[1:0] == 2'b00) && (bus.DataAdr[31:8] == 24'd0);
  assign adr_idx = bus.DataAdr[7:2];

  // Next-state, memory update and output computation.
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    rd_idx_d    = rd_idx_q;
    rd_ok_d     = rd_ok_q;
    rdata_d     = '0;
    rd_valid_d  = 1'b0;
    adr_err_d   = adr_err_q;
    proto_err_d = proto_err_q;
    watch_d     = watch_q;
    wr_count_d  = wr_count_q;

    unique case (state_q)
      IDLE: begin
        if (bus.MemWrite) begin
          // A simultaneous read is dropped; the write still goes ahead.
          if (bus.MemRead) begin
            proto_err_d = 1'b1;
          end
          if (adr_ok) begin
            mem_d[adr_idx] = bus.WriteData;
            if (wr_count_q != {CW{1'b1}}) begin
              wr_count_d = wr_count_q + CW'(1);
            end
          end else begin
            adr_err_d = 1'b1;
          end
          if ((bus.DataAdr == WATCH_ADR) && (bus.WriteData == WATCH_DATA)) begin
            watch_d = 1'b1;
          end
        end else if (bus.MemRead) begin
          rd_idx_d = adr_idx;
          rd_ok_d  = adr_ok;
          if (!adr_ok) begin
            adr_err_d = 1'b1;
          end
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        rd_valid_d = 1'b1;
        rdata_d    = rd_ok_q ? mem_q[rd_idx_q] : '0;
        state_d    = RD_RESP;
      end
      RD_RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  // All state, including the memory array, clears on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_q       <= '{default: '0};
      rd_idx_q    <= '0;
      rd_ok_q     <= 1'b0;
      rdata_q     <= '0;
      rd_valid_q  <= 1'b0;
      ready_q     <= 1'b1;
      adr_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
      watch_q     <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      rd_idx_q    <= rd_idx_d;
      rd_ok_q     <= rd_ok_d;
      rdata_q     <= rdata_d;
      rd_valid_q  <= rd_valid_d;
      ready_q     <= ready_d;
      adr_err_q   <= adr_err_d;
      proto_err_q <= proto_err_d;
      watch_q     <= watch_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign bus.ReadData = rdata_q;
  assign bus.RdValid  = rd_valid_q;
  assign bus.Ready    = ready_q;
  assign bus.AdrErr   = adr_err_q;
  assign bus.ProtoErr = proto_err_q;
  assign bus.WatchHit = watch_q;
  assign bus.WrCount  = wr_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table of single operations with
// expected read data and flag state, plus hand-written multi-cycle sequences.
module tb_dmem_responder;

  localparam logic [1:0] OP_W  = 2'd0;
  localparam logic [1:0] OP_R  = 2'd1;
  localparam logic [1:0] OP_WR = 2'd2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(
    .WATCH_ADR  (32'd64),
    .WATCH_DATA (32'd64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst;
    logic [1:0]  op;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_adr_err;
    logic        exp_proto;
    logic        exp_watch;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.DataAdr   = 32'd0;
    bus.WriteData = 32'd0;
  endtask

  // Entered and left on a falling edge; the next rising edge accepts a request.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic op_write(input logic [31:0] adr, input logic [31:0] data);
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = adr;
    bus.WriteData = data;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic op_both(input string name, input logic [31:0] adr, input logic [31:0] data);
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b1;
    bus.DataAdr   = adr;
    bus.WriteData = data;
    @(negedge clk);
    idle_inputs();
    chk1({name, "_ready"}, bus.Ready, 1'b1);
    chk1({name, "_rdvalid0"}, bus.RdValid, 1'b0);
    @(negedge clk);
    chk1({name, "_rdvalid1"}, bus.RdValid, 1'b0);
  endtask

  task automatic op_read(input string name, input logic [31:0] adr, input logic [31:0] exp);
    bus.MemRead = 1'b1;
    bus.DataAdr = adr;
    @(negedge clk);
    idle_inputs();
    chk1({name, "_wait_ready"}, bus.Ready, 1'b0);
    chk1({name, "_wait_rdvalid"}, bus.RdValid, 1'b0);
    @(negedge clk);
    chk1({name, "_resp_ready"}, bus.Ready, 1'b0);
    chk1({name, "_resp_rdvalid"}, bus.RdValid, 1'b1);
    chk({name, "_resp_rdata"}, bus.ReadData, exp);
    @(negedge clk);
    chk1({name, "_done_ready"}, bus.Ready, 1'b1);
    chk1({name, "_done_rdvalid"}, bus.RdValid, 1'b0);
    chk({name, "_done_rdata"}, bus.ReadData, 32'd0);
  endtask

  function automatic void add(input bit rst, input logic [1:0] op, input logic [31:0] adr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic ae, input logic pe, input logic wh,
                              input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.op = op; v.adr = adr; v.wdata = wdata; v.exp_rdata = exp_rdata;
    v.exp_adr_err = ae; v.exp_proto = pe; v.exp_watch = wh; v.exp_cnt = cnt;
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1'b0;
    idle_inputs();

    //   rst op     adr            wdata          exp_rdata      ae    pe    wh    cnt
    add(1, OP_W,  32'h0000_0020, 32'h1234_5678, 32'h0,         1'b0, 1'b0, 1'b0, 16'd1);
    add(0, OP_R,  32'h0000_0020, 32'h0,         32'h1234_5678, 1'b0, 1'b0, 1'b0, 16'd1);
    add(1, OP_W,  32'h0000_0040, 32'd64,        32'h0,         1'b0, 1'b0, 1'b1, 16'd1);
    add(0, OP_W,  32'h0000_0060, 32'd64,        32'h0,         1'b0, 1'b0, 1'b1, 16'd2);
    add(0, OP_R,  32'h0000_0040, 32'h0,         32'd64,        1'b0, 1'b0, 1'b1, 16'd2);
    add(0, OP_R,  32'h0000_0060, 32'h0,         32'd64,        1'b0, 1'b0, 1'b1, 16'd2);
    add(1, OP_W,  32'h0000_0022, 32'hDEAD_BEEF, 32'h0,         1'b1, 1'b0, 1'b0, 16'd0);
    add(0, OP_W,  32'h0000_0100, 32'h1111_1111, 32'h0,         1'b1, 1'b0, 1'b0, 16'd0);
    add(0, OP_R,  32'h0000_0100, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 16'd0);
    add(0, OP_R,  32'h0000_0020, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 16'd0);
    add(0, OP_R,  32'h0000_0000, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 16'd0);
    add(1, OP_R,  32'h0000_0004, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 16'd0);
    add(0, OP_R,  32'h0000_0101, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 16'd0);
    add(1, OP_WR, 32'h0000_0010, 32'h0000_00A5, 32'h0,         1'b0, 1'b1, 1'b0, 16'd1);
    add(0, OP_R,  32'h0000_0010, 32'h0,         32'h0000_00A5, 1'b0, 1'b1, 1'b0, 16'd1);
    add(0, OP_W,  32'h0000_0040, 32'd65,        32'h0,         1'b0, 1'b1, 1'b0, 16'd2);
    add(0, OP_W,  32'h0000_00FC, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1, 1'b0, 16'd3);
    add(0, OP_R,  32'h0000_00FC, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 16'd3);

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    chk1("rst_ready", bus.Ready, 1'b1);
    chk1("rst_rdvalid", bus.RdValid, 1'b0);
    chk("rst_rdata", bus.ReadData, 32'd0);
    chk1("rst_adrerr", bus.AdrErr, 1'b0);
    chk1("rst_protoerr", bus.ProtoErr, 1'b0);
    chk1("rst_watch", bus.WatchHit, 1'b0);
    chk("rst_wrcount", 32'(bus.WrCount), 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("v%0d", i);
      if (vecs[i].rst) do_reset();
      case (vecs[i].op)
        OP_W:    op_write(vecs[i].adr, vecs[i].wdata);
        OP_R:    op_read(nm, vecs[i].adr, vecs[i].exp_rdata);
        default: op_both(nm, vecs[i].adr, vecs[i].wdata);
      endcase
      chk1({nm, "_adrerr"}, bus.AdrErr, vecs[i].exp_adr_err);
      chk1({nm, "_protoerr"}, bus.ProtoErr, vecs[i].exp_proto);
      chk1({nm, "_watch"}, bus.WatchHit, vecs[i].exp_watch);
      chk({nm, "_wrcount"}, 32'(bus.WrCount), 32'(vecs[i].exp_cnt));
    end

    // Requests presented while a read is in flight are ignored.
    do_reset();
    op_write(32'h20, 32'hCAFE_0001);
    bus.MemRead = 1'b1;
    bus.DataAdr = 32'h20;
    @(negedge clk);
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b1;
    bus.DataAdr   = 32'h28;
    bus.WriteData = 32'h77;
    @(negedge clk);
    chk1("busy_rdvalid", bus.RdValid, 1'b1);
    chk("busy_rdata", bus.ReadData, 32'hCAFE_0001);
    idle_inputs();
    @(negedge clk);
    chk("busy_wrcount", 32'(bus.WrCount), 32'd1);
    chk1("busy_protoerr", bus.ProtoErr, 1'b0);
    chk1("busy_ready", bus.Ready, 1'b1);
    op_read("busy_rd28", 32'h28, 32'h0);

    // Reset during RD_WAIT aborts the read; first edge after release accepts a write.
    do_reset();
    op_write(32'h20, 32'h55);
    bus.MemRead = 1'b1;
    bus.DataAdr = 32'h20;
    @(negedge clk);
    idle_inputs();
    chk1("abort_wait_ready", bus.Ready, 1'b0);
    reset = 1'b0;
    #1;
    chk1("abort_async_ready", bus.Ready, 1'b1);
    chk("abort_async_wrcount", 32'(bus.WrCount), 32'd0);
    @(negedge clk);
    chk1("abort_held_rdvalid", bus.RdValid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = 32'h8;
    bus.WriteData = 32'h99;
    @(negedge clk);
    idle_inputs();
    chk1("abort_rel_rdvalid0", bus.RdValid, 1'b0);
    chk("abort_rel_wrcount", 32'(bus.WrCount), 32'd1);
    chk1("abort_rel_ready", bus.Ready, 1'b1);
    @(negedge clk);
    chk1("abort_rel_rdvalid1", bus.RdValid, 1'b0);
    chk("abort_rel_rdata", bus.ReadData, 32'd0);
    op_read("abort_mem_cleared", 32'h20, 32'h0);
    op_read("abort_first_write", 32'h8, 32'h99);

    // WrCount saturation: back-to-back legal writes held for 65534 edges, then 3 more.
    do_reset();
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = 32'h0;
    bus.WriteData = 32'h1;
    repeat (65534) @(negedge clk);
    chk("sat_fffe", 32'(bus.WrCount), 32'h0000_FFFE);
    repeat (3) @(negedge clk);
    idle_inputs();
    chk("sat_ffff", 32'(bus.WrCount), 32'h0000_FFFF);
    @(negedge clk);
    chk("sat_hold", 32'(bus.WrCount), 32'h0000_FFFF);
    chk1("sat_adrerr", bus.AdrErr, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
